sc_fibomonitor: RTL and testbench

Receiving end of the Fibonacci system output bus. Captures each term the uDATAPATH drives onto its 8-bit data bus when a one-cycle strobe marks it valid. Checks every term against the Fibonacci recurrence and stores accepted terms in a small circular buffer that can be read back. Reports progress, completion on 8-bit wrap, and a sticky fault to the board/display logic alongside BB_SYSTEM.

---
 rtl/sc_fibomonitor_if.sv | 40 ++++
 rtl/sc_fibomonitor.sv | 174 +++++++++++++++++
 tb/tb_sc_fibomonitor.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_fibomonitor_if.sv
// Fibonacci output bus as seen by the monitor: term strobe, control, buffer readback and status.
// The master side is the datapath/board driver and the slave side is the monitor.
interface sc_fibomonitor_if #(
    parameter int DATAWIDTH_BUS     = 8,
    parameter int BUFFER_ADDR_WIDTH = 3,
    parameter int DATAWIDTH_STATE   = 3
);
    logic [DATAWIDTH_BUS-1:0]     SC_FIBOMONITOR_data_InBUS;
    logic                         SC_FIBOMONITOR_datavalid_InHigh;
    logic                         SC_FIBOMONITOR_enable_InHigh;
    logic                         SC_FIBOMONITOR_clear_InHigh;
    logic [BUFFER_ADDR_WIDTH-1:0] SC_FIBOMONITOR_readaddress_InBUS;
    logic [DATAWIDTH_BUS-1:0]     SC_FIBOMONITOR_readdata_OutBUS;
    logic [7:0]                   SC_FIBOMONITOR_termcount_OutBUS;
    logic                         SC_FIBOMONITOR_newterm_OutHigh;
    logic                         SC_FIBOMONITOR_done_OutHigh;
    logic                         SC_FIBOMONITOR_overflow_OutHigh;
    logic                         SC_FIBOMONITOR_fault_OutHigh;
    logic [DATAWIDTH_STATE-1:0]   SC_FIBOMONITOR_state_OutBUS;

    modport master (
        output SC_FIBOMONITOR_data_InBUS, SC_FIBOMONITOR_datavalid_InHigh,
               SC_FIBOMONITOR_enable_InHigh, SC_FIBOMONITOR_clear_InHigh,
               SC_FIBOMONITOR_readaddress_InBUS,
        input  SC_FIBOMONITOR_readdata_OutBUS, SC_FIBOMONITOR_termcount_OutBUS,
               SC_FIBOMONITOR_newterm_OutHigh, SC_FIBOMONITOR_done_OutHigh,
               SC_FIBOMONITOR_overflow_OutHigh, SC_FIBOMONITOR_fault_OutHigh,
               SC_FIBOMONITOR_state_OutBUS
    );

    modport slave (
        input  SC_FIBOMONITOR_data_InBUS, SC_FIBOMONITOR_datavalid_InHigh,
               SC_FIBOMONITOR_enable_InHigh, SC_FIBOMONITOR_clear_InHigh,
               SC_FIBOMONITOR_readaddress_InBUS,
        output SC_FIBOMONITOR_readdata_OutBUS, SC_FIBOMONITOR_termcount_OutBUS,
               SC_FIBOMONITOR_newterm_OutHigh, SC_FIBOMONITOR_done_OutHigh,
               SC_FIBOMONITOR_overflow_OutHigh, SC_FIBOMONITOR_fault_OutHigh,
               SC_FIBOMONITOR_state_OutBUS
    );
endinterface

// File: rtl/sc_fibomonitor.sv
// Fibonacci term monitor: checks each strobed term against the recurrence and logs accepted terms in a circular buffer.
// Status flags one cycle after the deciding strobe, readback one cycle; no backpressure, one term per cycle accepted.
module sc_fibomonitor #(
    parameter int DATAWIDTH_BUS     = 8,
    parameter int BUFFER_ADDR_WIDTH = 3,
    parameter int DATAWIDTH_STATE   = 3
) (
    input  logic            SC_FIBOMONITOR_CLOCK_50,
    input  logic            SC_FIBOMONITOR_RESET_InHigh,
    sc_fibomonitor_if.slave bus
);
    localparam int DEPTH = 1 << BUFFER_ADDR_WIDTH;
    localparam logic [BUFFER_ADDR_WIDTH-1:0] PTR_ONE = 1;

    typedef enum logic [DATAWIDTH_STATE-1:0] {
        S_IDLE  = 3'd0,
        S_SEED0 = 3'd1,
        S_SEED1 = 3'd2,
        S_TRACK = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t                       state_q, state_d;
    logic [DATAWIDTH_BUS-1:0]     prev1_q, prev1_d;
    logic [DATAWIDTH_BUS-1:0]     prev2_q, prev2_d;
    logic [BUFFER_ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [7:0]                   termcount_q, termcount_d;
    logic                         newterm_q, newterm_d;
    logic                         done_q, done_d;
    logic                         overflow_q, overflow_d;
    logic                         fault_q, fault_d;
    logic [DATAWIDTH_BUS-1:0]     readdata_q, readdata_d;
    logic [DATAWIDTH_BUS:0]       expected;
    logic                         accept;
    logic                         go_fault;
    logic                         wr_en;
    logic [DATAWIDTH_BUS-1:0]     buf_mem [DEPTH];

    logic                         clk;
    logic                         rst;
    logic [DATAWIDTH_BUS-1:0]     data;
    logic                         vld;

    assign clk  = SC_FIBOMONITOR_CLOCK_50;
    assign rst  = SC_FIBOMONITOR_RESET_InHigh;
    assign data = bus.SC_FIBOMONITOR_data_InBUS;
    assign vld  = bus.SC_FIBOMONITOR_datavalid_InHigh;

    always_comb begin
        state_d     = state_q;
        prev1_d     = prev1_q;
        prev2_d     = prev2_q;
        ptr_d       = ptr_q;
        termcount_d = termcount_q;
        done_d      = done_q;
        overflow_d  = overflow_q;
        fault_d     = fault_q;
        accept      = 1'b0;
        go_fault    = 1'b0;
        // 9-bit sum so the carry out marks the term that wrapped past 8 bits
        expected    = {1'b0, prev1_q} + {1'b0, prev2_q};

        if (bus.SC_FIBOMONITOR_clear_InHigh) begin
            state_d     = S_IDLE;
            prev1_d     = '0;
            prev2_d     = '0;
            ptr_d       = '0;
            termcount_d = '0;
            done_d      = 1'b0;
            overflow_d  = 1'b0;
            fault_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.SC_FIBOMONITOR_enable_InHigh) state_d = S_SEED0;
                end
                S_SEED0: begin
                    if (vld) begin
                        if (data == '0) begin
                            accept  = 1'b1;
                            state_d = S_SEED1;
                        end else begin
                            go_fault = 1'b1;
                        end
                    end
                end
                S_SEED1: begin
                    if (vld) begin
                        if (data == DATAWIDTH_BUS'(1)) begin
                            accept  = 1'b1;
                            prev2_d = '0;
                            prev1_d = DATAWIDTH_BUS'(1);
                            state_d = S_TRACK;
                        end else begin
                            go_fault = 1'b1;
                        end
                    end
                end
                S_TRACK: begin
                    if (vld) begin
                        if (data != expected[DATAWIDTH_BUS-1:0]) begin
                            go_fault = 1'b1;
                        end else if (expected[DATAWIDTH_BUS]) begin
                            accept     = 1'b1;
                            overflow_d = 1'b1;
                            done_d     = 1'b1;
                            state_d    = S_DONE;
                        end else begin
                            accept  = 1'b1;
                            prev2_d = prev1_q;
                            prev1_d = data;
                        end
                    end
                end
                S_DONE:  state_d = S_DONE;
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_IDLE;
            endcase

            if (go_fault) begin
                state_d = S_FAULT;
                fault_d = 1'b1;
            end
            if (accept) begin
                ptr_d = ptr_q + PTR_ONE;
                if (termcount_q != 8'hFF) termcount_d = termcount_q + 8'd1;
            end
        end

        newterm_d  = accept;
        wr_en      = accept & ~rst;
        readdata_d = buf_mem[bus.SC_FIBOMONITOR_readaddress_InBUS];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prev1_q     <= '0;
            prev2_q     <= '0;
            ptr_q       <= '0;
            termcount_q <= '0;
            newterm_q   <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            fault_q     <= 1'b0;
            readdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            prev1_q     <= prev1_d;
            prev2_q     <= prev2_d;
            ptr_q       <= ptr_d;
            termcount_q <= termcount_d;
            newterm_q   <= newterm_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            fault_q     <= fault_d;
            readdata_q  <= readdata_d;
        end
    end

    // Buffer storage is deliberately not reset; old words remain readable
    always_ff @(posedge clk) begin
        if (wr_en) buf_mem[ptr_q] <= data;
    end

    assign bus.SC_FIBOMONITOR_readdata_OutBUS  = readdata_q;
    assign bus.SC_FIBOMONITOR_termcount_OutBUS = termcount_q;
    assign bus.SC_FIBOMONITOR_newterm_OutHigh  = newterm_q;
    assign bus.SC_FIBOMONITOR_done_OutHigh     = done_q;
    assign bus.SC_FIBOMONITOR_overflow_OutHigh = overflow_q;
    assign bus.SC_FIBOMONITOR_fault_OutHigh    = fault_q;
    assign bus.SC_FIBOMONITOR_state_OutBUS     = state_q;
endmodule

// File: tb/tb_sc_fibomonitor.sv
// Bench for sc_fibomonitor: table-driven term sequences, newterm scoreboard and a shadow buffer model.
module tb_sc_fibomonitor;
    localparam int W = 8;
    localparam int A = 3;
    localparam int S = 3;

    localparam int ST_IDLE  = 0;
    localparam int ST_SEED0 = 1;
    localparam int ST_SEED1 = 2;
    localparam int ST_TRACK = 3;
    localparam int ST_DONE  = 4;
    localparam int ST_FAULT = 5;

    typedef struct {
        logic [7:0] data;
        logic       acc;
        int         cnt;
        int         st;
        int         done;
        int         fault;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sc_fibomonitor_if #(.DATAWIDTH_BUS(W), .BUFFER_ADDR_WIDTH(A), .DATAWIDTH_STATE(S)) bus ();

    sc_fibomonitor #(.DATAWIDTH_BUS(W), .BUFFER_ADDR_WIDTH(A), .DATAWIDTH_STATE(S)) dut (
        .SC_FIBOMONITOR_CLOCK_50    (clk),
        .SC_FIBOMONITOR_RESET_InHigh(rst),
        .bus                        (bus.slave)
    );

    int         total = 0;
    int         bad = 0;
    int         sb_q[$];
    vec_t       tbl[$];
    logic [7:0] mdl_buf[8];
    int         mdl_ptr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Each newterm pulse must match the oldest pending accepted term
    always @(negedge clk) begin
        if (bus.SC_FIBOMONITOR_newterm_OutHigh === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("newterm_unexpected", 32'd1, 32'd0);
            end else begin
                chk("newterm_count", 32'(bus.SC_FIBOMONITOR_termcount_OutBUS), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic add(input logic [7:0] d, input logic acc, input int cnt, input int st,
                       input int dn, input int flt);
        vec_t v;
        v.data = d; v.acc = acc; v.cnt = cnt; v.st = st; v.done = dn; v.fault = flt;
        tbl.push_back(v);
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        chk({tag, "_count"}, 32'(bus.SC_FIBOMONITOR_termcount_OutBUS), 32'(v.cnt));
        chk({tag, "_state"}, 32'(bus.SC_FIBOMONITOR_state_OutBUS), 32'(v.st));
        chk({tag, "_done"},  32'(bus.SC_FIBOMONITOR_done_OutHigh), 32'(v.done));
        chk({tag, "_fault"}, 32'(bus.SC_FIBOMONITOR_fault_OutHigh), 32'(v.fault));
    endtask

    // Back-to-back strobes; results of strobe i are checked while strobe i+1 is driven
    task automatic run_tbl(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            if (i > 0) check_vec(tag, tbl[i-1]);
            bus.SC_FIBOMONITOR_data_InBUS       = tbl[i].data;
            bus.SC_FIBOMONITOR_datavalid_InHigh = 1'b1;
            if (tbl[i].acc) begin
                sb_q.push_back(tbl[i].cnt);
                mdl_buf[mdl_ptr] = tbl[i].data;
                mdl_ptr = (mdl_ptr + 1) % 8;
            end
        end
        @(negedge clk);
        check_vec(tag, tbl[tbl.size()-1]);
        bus.SC_FIBOMONITOR_datavalid_InHigh = 1'b0;
    endtask

    task automatic enable_mon();
        @(negedge clk);
        bus.SC_FIBOMONITOR_enable_InHigh = 1'b1;
        @(negedge clk);
        bus.SC_FIBOMONITOR_enable_InHigh = 1'b0;
        chk("enable_state", 32'(bus.SC_FIBOMONITOR_state_OutBUS), ST_SEED0);
    endtask

    task automatic clear_mon();
        @(negedge clk);
        bus.SC_FIBOMONITOR_clear_InHigh = 1'b1;
        @(negedge clk);
        bus.SC_FIBOMONITOR_clear_InHigh = 1'b0;
        mdl_ptr = 0;
        chk("clear_state", 32'(bus.SC_FIBOMONITOR_state_OutBUS), ST_IDLE);
        chk("clear_count", 32'(bus.SC_FIBOMONITOR_termcount_OutBUS), 0);
        chk("clear_fault", 32'(bus.SC_FIBOMONITOR_fault_OutHigh), 0);
        chk("clear_done",  32'(bus.SC_FIBOMONITOR_done_OutHigh), 0);
        chk("clear_ovf",   32'(bus.SC_FIBOMONITOR_overflow_OutHigh), 0);
    endtask

    task automatic read_check(input string tag, input int n);
        for (int a = 0; a < n; a++) begin
            @(negedge clk);
            bus.SC_FIBOMONITOR_readaddress_InBUS = A'(a);
            @(negedge clk);
            chk({tag, "_rd"}, 32'(bus.SC_FIBOMONITOR_readdata_OutBUS), 32'(mdl_buf[a]));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"}, 32'(bus.SC_FIBOMONITOR_state_OutBUS), 0);
        chk({tag, "_count"}, 32'(bus.SC_FIBOMONITOR_termcount_OutBUS), 0);
        chk({tag, "_newterm"}, 32'(bus.SC_FIBOMONITOR_newterm_OutHigh), 0);
        chk({tag, "_done"}, 32'(bus.SC_FIBOMONITOR_done_OutHigh), 0);
        chk({tag, "_ovf"}, 32'(bus.SC_FIBOMONITOR_overflow_OutHigh), 0);
        chk({tag, "_fault"}, 32'(bus.SC_FIBOMONITOR_fault_OutHigh), 0);
        chk({tag, "_rdata"}, 32'(bus.SC_FIBOMONITOR_readdata_OutBUS), 0);
    endtask

    task automatic load_nominal();
        logic [7:0] terms [15];
        terms = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34,
                  8'd55, 8'd89, 8'd144, 8'd233, 8'd121};
        tbl.delete();
        for (int i = 0; i < 15; i++) begin
            add(terms[i], 1'b1, i + 1,
                (i == 0) ? ST_SEED1 : (i == 14) ? ST_DONE : ST_TRACK,
                (i == 14) ? 1 : 0, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.SC_FIBOMONITOR_data_InBUS        = '0;
        bus.SC_FIBOMONITOR_datavalid_InHigh  = 1'b0;
        bus.SC_FIBOMONITOR_enable_InHigh     = 1'b0;
        bus.SC_FIBOMONITOR_clear_InHigh      = 1'b0;
        bus.SC_FIBOMONITOR_readaddress_InBUS = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Strobes while idle and not enabled are ignored
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.SC_FIBOMONITOR_data_InBUS       = 8'(i);
            bus.SC_FIBOMONITOR_datavalid_InHigh = 1'b1;
        end
        @(negedge clk);
        bus.SC_FIBOMONITOR_datavalid_InHigh = 1'b0;
        @(negedge clk);
        chk("idle_count", 32'(bus.SC_FIBOMONITOR_termcount_OutBUS), 0);
        chk("idle_state", 32'(bus.SC_FIBOMONITOR_state_OutBUS), ST_IDLE);

        // Nominal run through the 8-bit wrap
        enable_mon();
        load_nominal();
        run_tbl("nominal");
        chk("nominal_ovf", 32'(bus.SC_FIBOMONITOR_overflow_OutHigh), 1);
        @(negedge clk);
        bus.SC_FIBOMONITOR_data_InBUS       = 8'd99;
        bus.SC_FIBOMONITOR_datavalid_InHigh = 1'b1;
        @(negedge clk);
        bus.SC_FIBOMONITOR_datavalid_InHigh = 1'b0;
        @(negedge clk);
        chk("done_hold_count", 32'(bus.SC_FIBOMONITOR_termcount_OutBUS), 15);
        chk("nominal_pulses", 32'(sb_q.size()), 0);
        read_check("wrap", 8);
        chk("wrap_slot0_is_21", 32'(mdl_buf[0]), 21);
        chk("wrap_slot7_is_13", 32'(mdl_buf[7]), 13);

        // Mismatch in the middle of the sequence
        clear_mon();
        enable_mon();
        tbl.delete();
        add(8'd0, 1'b1, 1, ST_SEED1, 0, 0);
        add(8'd1, 1'b1, 2, ST_TRACK, 0, 0);
        add(8'd1, 1'b1, 3, ST_TRACK, 0, 0);
        add(8'd2, 1'b1, 4, ST_TRACK, 0, 0);
        add(8'd4, 1'b0, 4, ST_FAULT, 0, 1);
        run_tbl("miderr");
        read_check("miderr", 4);
        @(negedge clk);
        bus.SC_FIBOMONITOR_data_InBUS       = 8'd3;
        bus.SC_FIBOMONITOR_datavalid_InHigh = 1'b1;
        @(negedge clk);
        bus.SC_FIBOMONITOR_datavalid_InHigh = 1'b0;
        @(negedge clk);
        chk("fault_hold_count", 32'(bus.SC_FIBOMONITOR_termcount_OutBUS), 4);

        // Bad first seed
        clear_mon();
        enable_mon();
        tbl.delete();
        add(8'd1, 1'b0, 0, ST_FAULT, 0, 1);
        run_tbl("badseed");
        clear_mon();

        // Clear colliding with a valid strobe in TRACK drops the term
        enable_mon();
        tbl.delete();
        add(8'd0, 1'b1, 1, ST_SEED1, 0, 0);
        add(8'd1, 1'b1, 2, ST_TRACK, 0, 0);
        add(8'd1, 1'b1, 3, ST_TRACK, 0, 0);
        run_tbl("precoll");
        @(negedge clk);
        bus.SC_FIBOMONITOR_data_InBUS       = 8'd2;
        bus.SC_FIBOMONITOR_datavalid_InHigh = 1'b1;
        bus.SC_FIBOMONITOR_clear_InHigh     = 1'b1;
        @(negedge clk);
        bus.SC_FIBOMONITOR_datavalid_InHigh = 1'b0;
        bus.SC_FIBOMONITOR_clear_InHigh     = 1'b0;
        mdl_ptr = 0;
        chk("coll_state", 32'(bus.SC_FIBOMONITOR_state_OutBUS), ST_IDLE);
        chk("coll_count", 32'(bus.SC_FIBOMONITOR_termcount_OutBUS), 0);
        chk("coll_newterm", 32'(bus.SC_FIBOMONITOR_newterm_OutHigh), 0);

        // Reset after six terms, then a full run again
        enable_mon();
        load_nominal();
        for (int i = 0; i < 9; i++) void'(tbl.pop_back());
        run_tbl("prereset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_ptr = 0;
        check_all_zero("midreset");
        enable_mon();
        load_nominal();
        run_tbl("rerun");
        chk("rerun_ovf", 32'(bus.SC_FIBOMONITOR_overflow_OutHigh), 1);
        read_check("rerun", 8);

        repeat (2) @(negedge clk);
        chk("final_pulses", 32'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
